// File: rtl/ts_pkg.sv
// Shared definitions for the timestamper record format.
// These definitions are used by both the capture stage and the serializer.
package ts_pkg;

   // The channel and lost bits sit directly above the timestamp field.
   // Their absolute bit index is TS_WIDTH + offset.
   localparam int REC_TS_LSB   = 0;
   localparam int REC_CH_BIT   = 0;
   localparam int REC_LOST_BIT = 1;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

   function automatic int rec_width(input int ts_w);
      return ts_w + 2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// A write to a full FIFO is accepted when a read happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_rd, do_wr;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_wr) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // Storage is not reset, so the output is masked to 0 while the FIFO is empty.
      rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/timestamp_capture.sv
// Timestamper front end. It synchronizes two event inputs, detects rising edges and tags each edge
// with a free-running counter value. Records are buffered in a FIFO for the serializer.
module timestamp_capture
   import ts_pkg::*;
#(
   parameter int TS_WIDTH   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                datain_ch0,
   input  logic                datain_ch1,
   output logic [TS_WIDTH+1:0] rec_data,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [TS_WIDTH-1:0] ts_count
);

   localparam int REC_W = rec_width(TS_WIDTH);
   localparam logic [TS_WIDTH-1:0] CNT_ONE = 1;

   logic [TS_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [1:0]          pend_q, pend_d, lost_q, lost_d;
   logic [TS_WIDTH-1:0] ts_q [2];
   logic [TS_WIDTH-1:0] ts_d [2];
   logic [1:0]          din, edge_det, xfer;
   logic                fifo_full, fifo_empty, pop, can_push, wr_en;
   logic [REC_W-1:0]    wr_data;

   always_comb begin
      din     = {datain_ch1, datain_ch0};
      cnt_d   = cnt_q + CNT_ONE;
      sync1_d = din;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      edge_det = sync2_q & ~prev_q;

      // Channel 0 wins. A pop frees a slot in the same cycle, so a full FIFO can still take a record.
      pop      = rec_valid && rec_ready;
      can_push = !fifo_full || pop;
      xfer     = 2'b00;
      if (can_push) begin
         if (pend_q[0])      xfer[0] = 1'b1;
         else if (pend_q[1]) xfer[1] = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
         pend_d[i] = pend_q[i];
         lost_d[i] = lost_q[i];
         ts_d[i]   = ts_q[i];
         if (xfer[i]) begin
            pend_d[i] = 1'b0;
            lost_d[i] = 1'b0;
         end
         if (edge_det[i]) begin
            if (!pend_q[i] || xfer[i]) begin
               ts_d[i]   = cnt_q;
               pend_d[i] = 1'b1;
            end else begin
               lost_d[i] = 1'b1;
            end
         end
      end

      wr_en   = |xfer;
      wr_data = '0;
      if (xfer[0]) begin
         wr_data[TS_WIDTH+REC_LOST_BIT]        = lost_q[0];
         wr_data[TS_WIDTH+REC_CH_BIT]          = CH0;
         wr_data[TS_WIDTH-1:REC_TS_LSB]        = ts_q[0];
      end else if (xfer[1]) begin
         wr_data[TS_WIDTH+REC_LOST_BIT]        = lost_q[1];
         wr_data[TS_WIDTH+REC_CH_BIT]          = CH1;
         wr_data[TS_WIDTH-1:REC_TS_LSB]        = ts_q[1];
      end

      ts_count = cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pend_q  <= '0;
         lost_q  <= '0;
         ts_q[0] <= '0;
         ts_q[1] <= '0;
      end else begin
         cnt_q   <= cnt_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         pend_q  <= pend_d;
         lost_q  <= lost_d;
         ts_q[0] <= ts_d[0];
         ts_q[1] <= ts_d[1];
      end
   end

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (fifo_full),
      .rd_en   (pop),
      .rd_data (rec_data),
      .empty   (fifo_empty)
   );

   assign rec_valid = !fifo_empty;

endmodule

// File: doc/timestamp_capture.md
# timestamp_capture

Front-end capture stage of the timestamper, immediately upstream of the serializer that drives `serialout`. It synchronizes the two asynchronous inputs `datain_ch0` and `datain_ch1` and detects their rising edges. Each edge is tagged with the value of a free-running cycle counter. The resulting records are buffered in a small FIFO and handed to the serializer over a valid/ready handshake.

## Interface

Parameters:
- `TS_WIDTH`, default 32: timestamp counter width.
- `FIFO_DEPTH`, default 4: record FIFO depth; must be a power of 2 and ≥2.

Ports (the clock is `clk`; reset `rst` is asynchronous and active-high):
- `clk` input 1: single system clock.
- `rst` input 1: asynchronous, active-high reset.
- `datain_ch0` input 1: asynchronous event input, channel 0.
- `datain_ch1` input 1: asynchronous event input, channel 1.
- `rec_data` output `TS_WIDTH+2`: head record. Bit layout:
  - `[TS_WIDTH+1]` lost flag.
  - `[TS_WIDTH]` channel.
  - `[TS_WIDTH-1:0]` timestamp.
- `rec_valid` output 1: `rec_data` holds a valid record.
- `rec_ready` input 1: the serializer accepts the record.
- `ts_count` output `TS_WIDTH`: current counter value, for debug.

## Operation

Counter:
- Resets to 0 and increments by 1 every cycle.
- Wraps from all-ones to 0 silently; the serializer/host handles wrap.

Synchronization and edge detect, per channel:
- Two-flop synchronizer followed by a previous-value flop; all three reset to 0.
- A rising edge is detected in cycle D when sync output = 1 and previous = 0.
- An input already high at reset release produces one edge.

Pending register, per channel. Fields: `pend`, `ts`, `lost`.
- Edge in cycle D while `pend`=0, or while this channel is being transferred in D: load `ts`=counter value in D and set `pend`=1 at D+1.
- Edge while `pend`=1 and the channel is not transferred this cycle: the edge is dropped, `lost` is set to 1, and `ts` is unchanged.

Arbiter, one transfer per cycle:
- Transfers a pending record to the FIFO when the FIFO is not full. Channel 0 has fixed priority.
- On transfer, it writes {`lost`, ch, `ts`} and clears `pend` and `lost`, unless a new edge for that channel loads in the same cycle. In that case `pend` stays 1 and `lost` is cleared.

FIFO:
- First-word-fall-through: `rec_valid` = not empty, and `rec_data` = head record.
- Pop occurs when `rec_valid && rec_ready`.
- Push and pop in the same cycle are both allowed when full or empty.
- `rec_data` is don't-care when `rec_valid`=0, but is driven as 0 after reset.

Reset, including mid-operation:
- Counter, synchronizers, pending registers, and FIFO pointers are cleared immediately.
- `rec_valid`=0, `rec_data`=0, `ts_count`=0.
- In-flight records are discarded.

## Timing

Latency:
- Pin transition to detect: 2–3 cycles, depending on metastability/phase.
- Detect in cycle D: `pend` set at D+1.
- With an idle arbiter and a non-full FIFO, the record is written at the end of D+1 and `rec_valid`=1 at D+2.

Simultaneous edges on both channels in cycle D:
- Both pending registers load with the same `ts`.
- ch0 is written at D+1 and ch1 at D+2, assuming FIFO space.

Throughput and hold:
- Sustained throughput is 1 record/cycle.
- Any single channel can accept one new edge per cycle without loss while its pending register drains every cycle.
- `rec_data`/`rec_valid` stay stable while `rec_valid && !rec_ready`.
- FIFO full plus `rec_ready`=1: the pop and a push happen in the same cycle, so no bubble.

## Structure

Shared package `ts_pkg`:
- Field index constants: `REC_LOST_BIT`, `REC_CH_BIT`, `REC_TS_LSB`.
- Record width function of `TS_WIDTH`.
- Channel ID constants `CH0`=0, `CH1`=1.

Sub-module `sync_fifo`:
- Parameterized width/depth, FWFT.
- Pointers with an extra wrap bit for full/empty.
- Reused later by the serializer.

Everything else lives in the top module: synchronizers, edge detect, pending registers, arbiter, and counter.

## Test plan

1. Reset, release, no activity for 100 cycles: `rec_valid`=0 throughout, `ts_count`=100 at cycle 100 after release.
2. Single ch0 pulse whose detect occurs at counter=40: one record {lost=0, ch=0, ts=40}, `rec_valid` asserted at counter=42.
3. Both inputs rise in the same cycle, detect at counter=200: records {0,0,200} then {0,1,200} on consecutive cycles.
4. Hold `rec_ready`=0 and generate 7 ch1 edges, 10 cycles apart, with `FIFO_DEPTH`=4:
   - FIFO holds edges 1–4 and the pending register holds edge 5.
   - Edges 6–7 set `lost`.
   - After `rec_ready`=1, the 5th record carries lost=1 and the ts of edge 5, and exactly 5 records come out.
5. Force the counter near wrap (`TS_WIDTH`=8) with an edge at count 255 and another at count 1: ts values are 255 then 1 in order.
6. Assert `rst` mid-stream with 3 records queued: `rec_valid`=0 asynchronously, and after release no stale record appears and `ts_count` restarts at 0.
